tlc_fsm: RTL and testbench
==========================

TLC_FSM -- requirements
Module: tlc_fsm

Interface
REQ-001 Parameter T_NS_GREEN, default 30, minimum NS green duration in clock cycles (range 1..63).
REQ-002 Parameter T_YELLOW, default 4, yellow duration in cycles for either road (range 1..63).
REQ-003 Parameter T_ALL_RED, default 2, all-red clearance duration in cycles (range 1..63).
REQ-004 Parameter T_EW_GREEN, default 20, fixed EW green duration in cycles (range 1..63).
REQ-005 i_clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-006 i_rst  input  1  one clock; reset is asynchronous and active-low.
REQ-007 i_EW_vd  input  1  EW vehicle detect; high means a vehicle is waiting on EW; synchronous to i_clk.
REQ-008 o_NS_red, o_NS_yellow, o_NS_green  output  1 each  NS lamp drives, active-high.
REQ-009 o_EW_red, o_EW_yellow, o_EW_green  output  1 each  EW lamp drives, active-high.
REQ-010 count  output  6  cycles elapsed in the current state, starting at 0 on state entry.

Function
REQ-011 The FSM SHALL have exactly six states, cycled in this order: NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, then back to NS_G.
REQ-012 Lamp decode SHALL be Moore, taken from the state register only:
- NS_G: NS green, EW red.
- NS_Y: NS yellow, EW red.
- AR1, AR2: NS red, EW red.
- EW_G: NS red, EW green.
- EW_Y: NS red, EW yellow.
REQ-013 Each road SHALL have exactly one lamp asserted in every cycle; both greens SHALL never be asserted together.
REQ-014 count SHALL be set to 0 on the edge that enters a new state and SHALL increment by 1 on every other edge.
REQ-015 In NS_G, count SHALL saturate at T_NS_GREEN-1 and SHALL never wrap.
REQ-016 A request flag req SHALL be set on any edge where i_EW_vd=1 while the state is not EW_G.
REQ-017 req SHALL be held clear while the state is EW_G; i_EW_vd is ignored in EW_G.
REQ-018 NS_G SHALL go to NS_Y on the edge where count >= T_NS_GREEN-1 and (req=1 or i_EW_vd=1); otherwise NS_G SHALL be held indefinitely.
REQ-019 The timed states SHALL advance on the edge where count = T-1, with T as follows:
- NS_Y, EW_Y: T_YELLOW.
- AR1, AR2: T_ALL_RED.
- EW_G: T_EW_GREEN.
REQ-020 A vehicle arrival during the NS_G minimum time SHALL be remembered via req and served as soon as the minimum time expires.
REQ-021 An unused state encoding SHALL go to NS_G with count=0 on the next edge.

Reset
REQ-022 While i_rst=0, the following SHALL apply immediately, without waiting for a clock edge:
- state = NS_G, count = 0, req = 0.
- o_NS_green = 1, o_EW_red = 1, all other lamps = 0.
REQ-023 After i_rst rises, counting SHALL begin at the first rising edge of i_clk.
REQ-024 Asserting reset in any state, mid-phase, SHALL abort that phase and restore the REQ-022 values at once.

Verification
REQ-025 Reset held low, clock running -> NS green/EW red, count=0, no change on any edge.
REQ-026 Release reset, i_EW_vd=0 forever -> NS_G held; count stops at 29; no other state entered.
REQ-027 Release reset, i_EW_vd=1 constant, default parameters -> the following sequence SHALL repeat with period 62:
- NS_G for 30 cycles.
- NS_Y for 4 cycles.
- AR1 for 2 cycles.
- EW_G for 20 cycles.
- EW_Y for 4 cycles.
- AR2 for 2 cycles.
REQ-028 One-cycle i_EW_vd pulse at cycle 5 after reset release -> NS_Y entered when count reaches 29 (30th cycle in NS_G), then one full EW cycle, then NS_G held.
REQ-029 i_EW_vd toggling every 2.5 clock periods -> the REQ-027 timing holds; each road always has one lamp on; the two greens are never both on.
REQ-030 Reset pulled low during EW_G at count=10 -> NS green/EW red and count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tlc_fsm.sv
// Two-road traffic light controller: NS main road, EW side road.
// NS green rests until an EW vehicle is seen after its minimum time.
module tlc_fsm #(
  parameter int unsigned T_NS_GREEN = 30,
  parameter int unsigned T_YELLOW   = 4,
  parameter int unsigned T_ALL_RED  = 2,
  parameter int unsigned T_EW_GREEN = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_EW_vd,
  output logic       o_NS_red,
  output logic       o_NS_yellow,
  output logic       o_NS_green,
  output logic       o_EW_red,
  output logic       o_EW_yellow,
  output logic       o_EW_green,
  output logic [5:0] count
);

  localparam logic [2:0] NS_G = 3'd0;
  localparam logic [2:0] NS_Y = 3'd1;
  localparam logic [2:0] AR1  = 3'd2;
  localparam logic [2:0] EW_G = 3'd3;
  localparam logic [2:0] EW_Y = 3'd4;
  localparam logic [2:0] AR2  = 3'd5;

  localparam logic [5:0] NSG_LAST = 6'(T_NS_GREEN - 1);
  localparam logic [5:0] YEL_LAST = 6'(T_YELLOW - 1);
  localparam logic [5:0] AR_LAST  = 6'(T_ALL_RED - 1);
  localparam logic [5:0] EWG_LAST = 6'(T_EW_GREEN - 1);

  // {NS r,y,g, EW r,y,g}
  localparam logic [5:0] L_NSG = 6'b001_100;
  localparam logic [5:0] L_NSY = 6'b010_100;
  localparam logic [5:0] L_AR  = 6'b100_100;
  localparam logic [5:0] L_EWG = 6'b100_001;
  localparam logic [5:0] L_EWY = 6'b100_010;

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [5:0] count_nx;
  logic       req;
  logic       req_nx;
  logic       ew_want;
  logic       nsg_min;
  logic [5:0] lamps;

  assign ew_want = req | i_EW_vd;
  assign nsg_min = (count >= NSG_LAST);

  always_comb begin
    state_nx = state;
    count_nx = count + 6'd1;
    case (state)
      NS_G: begin
        if (nsg_min && ew_want) begin
          state_nx = NS_Y;
          count_nx = 6'd0;
        end else if (nsg_min) begin
          count_nx = NSG_LAST;
        end
      end
      NS_Y: begin
        if (count == YEL_LAST) begin
          state_nx = AR1;
          count_nx = 6'd0;
        end
      end
      AR1: begin
        if (count == AR_LAST) begin
          state_nx = EW_G;
          count_nx = 6'd0;
        end
      end
      EW_G: begin
        if (count == EWG_LAST) begin
          state_nx = EW_Y;
          count_nx = 6'd0;
        end
      end
      EW_Y: begin
        if (count == YEL_LAST) begin
          state_nx = AR2;
          count_nx = 6'd0;
        end
      end
      AR2: begin
        if (count == AR_LAST) begin
          state_nx = NS_G;
          count_nx = 6'd0;
        end
      end
      default: begin
        state_nx = NS_G;
        count_nx = 6'd0;
      end
    endcase
  end

  // The pending request is consumed by the EW green it asked for.
  always_comb begin
    req_nx = req;
    if (state == EW_G)
      req_nx = 1'b0;
    else if (i_EW_vd)
      req_nx = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= NS_G;
      count <= 6'd0;
      req   <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      req   <= req_nx;
    end
  end

  // Unused encodings show all-red until the next edge recovers NS_G.
  always_comb begin
    lamps = L_AR;
    case (state)
      NS_G:    lamps = L_NSG;
      NS_Y:    lamps = L_NSY;
      AR1:     lamps = L_AR;
      EW_G:    lamps = L_EWG;
      EW_Y:    lamps = L_EWY;
      AR2:     lamps = L_AR;
      default: lamps = L_AR;
    endcase
  end

  assign o_NS_red    = lamps[5];
  assign o_NS_yellow = lamps[4];
  assign o_NS_green  = lamps[3];
  assign o_EW_red    = lamps[2];
  assign o_EW_yellow = lamps[1];
  assign o_EW_green  = lamps[0];

endmodule

// File: tb/tb_tlc_fsm.sv
// Directed bench for tlc_fsm with default timing parameters.
// Lamp vectors are {NS r,y,g, EW r,y,g}.
module tb_tlc_fsm;

  logic       clk;
  logic       rst;
  logic       vd;
  logic       ns_r, ns_y, ns_g;
  logic       ew_r, ew_y, ew_g;
  logic [5:0] cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] NSG = 6'b001_100;
  localparam logic [5:0] NSY = 6'b010_100;
  localparam logic [5:0] AR  = 6'b100_100;
  localparam logic [5:0] EWG = 6'b100_001;
  localparam logic [5:0] EWY = 6'b100_010;

  tlc_fsm dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_EW_vd     (vd),
    .o_NS_red    (ns_r),
    .o_NS_yellow (ns_y),
    .o_NS_green  (ns_g),
    .o_EW_red    (ew_r),
    .o_EW_yellow (ew_y),
    .o_EW_green  (ew_g),
    .count       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vd;
    int         adv;
    logic [5:0] lamps;
    logic [5:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] lamps_now();
    return {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g};
  endfunction

  task automatic chk(input string name,
                     input logic [5:0] el,
                     input logic [5:0] ec);
    checks++;
    if (lamps_now() !== el || cnt !== ec) begin
      errors++;
      $display("FAIL %s: lamps=%b count=%0d, want lamps=%b count=%0d",
               name, lamps_now(), cnt, el, ec);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_safe(input string name);
    logic [5:0] l;
    l = lamps_now();
    checks++;
    if ($countones(l[5:3]) != 1 || $countones(l[2:0]) != 1
        || (l[3] && l[0])) begin
      errors++;
      $display("FAIL %s: lamps=%b not a legal pair", name, l);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    adv(2);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    vd  = 1'b1;
    #2;
    chk("reset_async_t0", NSG, 6'd0);
    adv(5);
    chk("reset_held", NSG, 6'd0);

    // constant demand: full 62-cycle cycle, then demand removed
    vecs.push_back('{1'b1, 0,  NSG, 6'd0});
    vecs.push_back('{1'b1, 29, NSG, 6'd29});
    vecs.push_back('{1'b1, 1,  NSY, 6'd0});
    vecs.push_back('{1'b1, 3,  NSY, 6'd3});
    vecs.push_back('{1'b1, 1,  AR,  6'd0});
    vecs.push_back('{1'b1, 1,  AR,  6'd1});
    vecs.push_back('{1'b1, 1,  EWG, 6'd0});
    vecs.push_back('{1'b1, 19, EWG, 6'd19});
    vecs.push_back('{1'b1, 1,  EWY, 6'd0});
    vecs.push_back('{1'b1, 3,  EWY, 6'd3});
    vecs.push_back('{1'b1, 1,  AR,  6'd0});
    vecs.push_back('{1'b1, 1,  AR,  6'd1});
    vecs.push_back('{1'b1, 1,  NSG, 6'd0});
    vecs.push_back('{1'b1, 29, NSG, 6'd29});
    vecs.push_back('{1'b1, 1,  NSY, 6'd0});
    vecs.push_back('{1'b0, 3,  NSY, 6'd3});
    vecs.push_back('{1'b0, 1,  AR,  6'd0});
    vecs.push_back('{1'b0, 2,  EWG, 6'd0});
    vecs.push_back('{1'b0, 20, EWY, 6'd0});
    vecs.push_back('{1'b0, 4,  AR,  6'd0});
    vecs.push_back('{1'b0, 2,  NSG, 6'd0});
    vecs.push_back('{1'b0, 29, NSG, 6'd29});
    vecs.push_back('{1'b0, 10, NSG, 6'd29});

    rst = 1'b1;
    foreach (vecs[i]) begin
      vd = vecs[i].vd;
      adv(vecs[i].adv);
      chk($sformatf("vec%0d", i), vecs[i].lamps, vecs[i].cnt);
    end

    // late arrival after minimum time is served on the next edge
    vd = 1'b1;
    adv(1);
    chk("late_vd_ns_y", NSY, 6'd0);
    vd = 1'b0;
    adv(4);
    chk("late_vd_ar1", AR, 6'd0);
    adv(2);
    chk("late_vd_ew_g", EWG, 6'd0);
    adv(10);
    chk("ew_g_cnt10", EWG, 6'd10);

    // reset mid EW green takes effect without a clock edge
    rst = 1'b0;
    #1;
    chk("reset_mid_ew_g", NSG, 6'd0);
    adv(3);
    chk("reset_mid_held", NSG, 6'd0);

    // one-cycle pulse at cycle 5 is remembered until min time ends
    rst = 1'b1;
    vd  = 1'b0;
    adv(5);
    chk("pulse_pre", NSG, 6'd5);
    vd = 1'b1;
    adv(1);
    vd = 1'b0;
    chk("pulse_cnt6", NSG, 6'd6);
    adv(23);
    chk("pulse_nsg29", NSG, 6'd29);
    adv(1);
    chk("pulse_ns_y", NSY, 6'd0);
    adv(6);
    chk("pulse_ew_g", EWG, 6'd0);
    adv(20);
    chk("pulse_ew_y", EWY, 6'd0);
    adv(6);
    chk("pulse_back_nsg", NSG, 6'd0);
    adv(40);
    chk("pulse_nsg_rest", NSG, 6'd29);

    // vd toggling every 2.5 periods keeps the fixed 62-cycle timing
    do_reset();
    vd = 1'b0;
    fork
      begin
        #2;
        repeat (60) begin
          #25 vd = ~vd;
        end
      end
      begin
        for (int n = 1; n <= 124; n++) begin
          adv(1);
          chk_safe($sformatf("toggle_safe%0d", n));
          if (n == 29) chk("toggle_nsg29", NSG, 6'd29);
          if (n == 30) chk("toggle_ns_y", NSY, 6'd0);
          if (n == 36) chk("toggle_ew_g", EWG, 6'd0);
          if (n == 56) chk("toggle_ew_y", EWY, 6'd0);
          if (n == 60) chk("toggle_ar2", AR, 6'd0);
          if (n == 62) chk("toggle_nsg", NSG, 6'd0);
          if (n == 124) chk("toggle_nsg2", NSG, 6'd0);
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
